// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte engine among N_REQ packet sources.
// Round-robin at packet granularity; the granted source keeps the engine
// until its last byte (or until MAX_BYTES forces the packet to end).
module uart_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BYTES = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_last,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_uart_start,
  output logic [7:0]         o_uart_data,
  input  logic               i_uart_busy,
  output logic               o_err
);

  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(MAX_BYTES + 1);
  // Wait counter runs 0..BUSY_WAIT-1 while waiting for busy to rise.
  localparam int WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   own_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               last_q;
  logic [N_REQ-1:0]   ack_q;
  logic [N_REQ-1:0]   grant_q;
  logic               start_q;
  logic               err_q;
  logic [7:0]         data_q;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               req_own;
  logic               last_own;
  logic [7:0]         byte_own;
  logic               wait_done;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % N_REQ);
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first active request at or after ptr_q, scanning cyclically.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[wrap_idx(int'(ptr_q) + k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(ptr_q) + k);
      end
    end
  end

  assign req_own   = i_req[own_q];
  assign last_own  = i_last[own_q];
  assign byte_own  = i_data[8*int'(own_q) +: 8];
  // A byte counts as taken once the engine reports busy, or after the timeout.
  assign wait_done = i_uart_busy || (wait_q == WAIT_W'(BUSY_WAIT - 1));

  // Arbitration FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            own_q   <= pick_idx;
            grant_q <= one_hot(pick_idx);
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!req_own) begin
            // Source abandoned its packet: free the engine, keep the pointer.
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (!i_uart_busy) begin
            data_q  <= byte_own;
            last_q  <= last_own;
            ack_q   <= one_hot(own_q);
            start_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
            wait_q  <= '0;
            state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (wait_done) begin
            state_q <= S_WAIT_LO;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WAIT_LO: begin
          if (!i_uart_busy) begin
            if (last_q || (cnt_q == CNT_W'(MAX_BYTES))) begin
              grant_q <= '0;
              ptr_q   <= wrap_idx(int'(own_q) + 1);
              cnt_q   <= '0;
              err_q   <= !last_q;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ack        = ack_q;
  assign o_grant      = grant_q;
  assign o_uart_start = start_q;
  assign o_uart_data  = data_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: packet-level round-robin reference model,
// randomized sources and a behavioural uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int MB = 8;
  localparam int BW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req, last, ack, grant;
  logic [15:0]  data;
  logic         start, busy, err;
  logic [7:0]   udata;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BYTES(MB), .BUSY_WAIT(BW)) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_data(data), .i_last(last),
    .o_ack(ack), .o_grant(grant), .o_uart_start(start), .o_uart_data(udata),
    .i_uart_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         src;
    logic [7:0] b;
    bit         first;
    bit         err_after;
  } exp_t;

  // Source packets: mode 0 = ends with i_last, 1 = never sets i_last (MB bytes),
  // 2 = source abandons after len bytes.
  int         pk_len  [2][$];
  int         pk_mode [2][$];
  logic [7:0] pk_byte [2][$];
  int         pos [2];
  int         cool [2];
  bit         wrel [2];

  exp_t exq[$];
  int   gq[$];
  int   exp_errs, errs_seen;

  int   tests = 0, fails = 0;
  int   cyc = 0, starts_seen, prev_start;
  int   first_req, first_grant, first_start;
  logic [1:0] prev_grant;
  logic [7:0] held;
  bit   err_flag;
  int   umode, urise, uhold;
  bit   ubusy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int r, input int mode, input int len,
                         input logic [63:0] fixed, input bit use_fixed);
    for (int i = 0; i < len; i++)
      pk_byte[r].push_back(use_fixed ? fixed[8*i +: 8] : 8'($urandom));
    pk_len[r].push_back(len);
    pk_mode[r].push_back(mode);
  endtask

  // Packet-level model: RR over sources with packets left; an abandoning source
  // sits out the next decision and leaves the pointer where it was.
  task automatic build_model();
    int cur [2];
    int boff [2];
    int ptr, cl, g, len, mode, r;
    exp_t e;
    exq.delete(); gq.delete(); exp_errs = 0;
    cur = '{0, 0}; boff = '{0, 0}; ptr = 0; cl = -1;
    while (cur[0] < pk_len[0].size() || cur[1] < pk_len[1].size()) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        r = (ptr + k) % N;
        if (g < 0 && cur[r] < pk_len[r].size() && r != cl) g = r;
      end
      for (int k = 0; k < N; k++) begin
        r = (ptr + k) % N;
        if (g < 0 && cur[r] < pk_len[r].size()) g = r;
      end
      gq.push_back(g);
      len  = pk_len[g][cur[g]];
      mode = pk_mode[g][cur[g]];
      for (int i = 0; i < len; i++) begin
        e.src = g; e.b = pk_byte[g][boff[g] + i];
        e.first = (i == 0); e.err_after = (mode == 1 && i == len - 1);
        exq.push_back(e);
      end
      boff[g] += len; cur[g]++;
      if (mode == 2) cl = g;
      else begin
        ptr = (g + 1) % N; cl = -1;
        if (mode == 1) exp_errs++;
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk); #1;
    cyc++;
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    if (start) begin
      starts_seen++;
      if (first_start < 0) first_start = cyc;
      chk("start_engine_idle", (ubusy || urise > 0) ? 1 : 0, 0);
      chk("start_expected", (exq.size() > 0) ? 1 : 0, 1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("start_data", udata, e.b);
        chk("start_grant", grant, 32'(1) << e.src);
        chk("start_ack", ack, 32'(1) << e.src);
        if (umode == 1 && !e.first) chk("busy_timeout_spacing", cyc - prev_start, BW + 2);
        err_flag = e.err_after;
      end
      held = udata;
      prev_start = cyc;
    end else begin
      chk("ack_without_start", ack, 0);
      chk("data_held", udata, held);
    end
    if (grant !== prev_grant) begin
      if (prev_grant != 0) chk("grant_via_idle", grant, 0);
      else begin
        if (first_grant < 0) first_grant = cyc;
        chk("grant_expected", (gq.size() > 0) ? 1 : 0, 1);
        if (gq.size() > 0) chk("grant_order", grant, 32'(1) << gq.pop_front());
      end
      prev_grant = grant;
    end
    if (err) begin
      errs_seen++;
      chk("err_after_unterminated", err_flag, 1);
      err_flag = 0;
    end
    // Engine model: busy rises 1..3 cycles after a start, holds 1..10 cycles.
    if (ubusy) begin
      uhold--;
      if (uhold == 0) ubusy = 0;
    end else if (urise > 0) begin
      urise--;
      if (urise == 0) begin ubusy = 1; uhold = $urandom_range(1, 10); end
    end
    if (start && umode == 0) urise = $urandom_range(1, 3);
    busy = ubusy;
    // Sources advance on ack and present their next byte.
    for (int r = 0; r < N; r++) begin
      if (ack[r] && pk_len[r].size() > 0) begin
        void'(pk_byte[r].pop_front());
        pos[r]++;
        if (pos[r] == pk_len[r][0]) begin
          if (pk_mode[r][0] == 2) wrel[r] = 1;
          void'(pk_len[r].pop_front());
          void'(pk_mode[r].pop_front());
          pos[r] = 0;
        end
      end
      req[r] = 1'b0; last[r] = 1'b0;
      if (wrel[r]) begin
        if (!grant[r]) begin wrel[r] = 0; cool[r] = 2; end
      end else if (cool[r] > 0) cool[r]--;
      else if (pk_len[r].size() > 0) begin
        req[r] = 1'b1;
        data[8*r +: 8] = pk_byte[r][0];
        last[r] = (pk_mode[r][0] == 0 && pos[r] == pk_len[r][0] - 1);
      end
    end
    if (first_req < 0 && req != 0) first_req = cyc;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_data"}, udata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic reset_dut();
    reset = 1'b1; req = '0; last = '0; data = '0; busy = 1'b0;
    ubusy = 0; urise = 0; uhold = 0;
    for (int r = 0; r < N; r++) begin
      pos[r] = 0; cool[r] = 0; wrel[r] = 0;
      pk_len[r].delete(); pk_mode[r].delete(); pk_byte[r].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    prev_grant = '0; held = '0; err_flag = 0; errs_seen = 0; starts_seen = 0;
    prev_start = -1; first_req = -1; first_grant = -1; first_start = -1;
  endtask

  function automatic bit phase_done();
    return exq.size() == 0 && pk_len[0].size() == 0 && pk_len[1].size() == 0 &&
           !wrel[0] && !wrel[1] && grant == 0;
  endfunction

  task automatic run_phase(input int um);
    int n;
    umode = um;
    build_model();
    n = 0;
    while (!phase_done() && n < 3000) begin cycle(); n++; end
    chk("phase_completed", phase_done() ? 1 : 0, 1);
    repeat (20) cycle();
    chk("starts_left", exq.size(), 0);
    chk("grants_left", gq.size(), 0);
    chk("err_count", errs_seen, exp_errs);
  endtask

  task automatic add_random(input int r, input int cnt, input bit mixed);
    int m;
    for (int i = 0; i < cnt; i++) begin
      m = mixed ? $urandom_range(0, 2) : 0;
      if (m == 1) add_pkt(r, 1, MB, 64'h0, 0);
      else if (m == 2) add_pkt(r, 2, $urandom_range(1, MB - 1), 64'h0, 0);
      else add_pkt(r, 0, $urandom_range(1, MB), 64'h0, 0);
    end
  endtask

  initial begin
    int n;
    umode = 0; reset = 1'b1; req = '0; last = '0; data = '0; busy = 1'b0;
    // Three-byte packet from requester 0, with grant/start latency.
    reset_dut();
    add_pkt(0, 0, 3, 64'h63_2A_05, 1);
    run_phase(0);
    chk("grant_latency", first_grant - first_req, 1);
    chk("start_latency", first_start - first_grant, 1);
    // Simultaneous requests, then back-to-back packets from both.
    reset_dut();
    add_random(0, 4, 0);
    add_random(1, 4, 0);
    run_phase(0);
    // Requester 1 abandons after one byte; requester 0 continues.
    reset_dut();
    add_pkt(0, 0, 2, 64'h0, 0);
    add_pkt(1, 2, 1, 64'h0, 0);
    add_pkt(0, 0, 3, 64'h0, 0);
    run_phase(0);
    // Unterminated packet is cut at MAX_BYTES; last on byte MAX_BYTES is normal.
    reset_dut();
    add_pkt(0, 1, MB, 64'h0, 0);
    add_pkt(1, 0, MB, 64'h0, 0);
    add_pkt(0, 0, 2, 64'h0, 0);
    run_phase(0);
    // Engine busy never rises: each byte finishes on the timeout.
    reset_dut();
    add_random(0, 2, 0);
    add_random(1, 2, 0);
    run_phase(1);
    // Random mix of normal, unterminated and abandoned packets.
    for (int rep = 0; rep < 3; rep++) begin
      reset_dut();
      add_random(0, 4, 1);
      add_random(1, 4, 1);
      run_phase(0);
    end
    // Reset while the second byte of the three-byte packet is in flight.
    reset_dut();
    add_pkt(0, 0, 3, 64'h63_2A_05, 1);
    umode = 0;
    build_model();
    n = 0;
    while (starts_seen < 2 && n < 200) begin cycle(); n++; end
    chk("mid_reset_second_start", starts_seen, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("mid_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
